// File: rtl/reg_display_scanner.sv
// Register-bank hex display scanner: manual select or timed auto-scan, with freeze.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module reg_display_scanner #(
    parameter int N_REGS      = 8,
    parameter int REG_W       = 16,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SEL_W       = $clog2(N_REGS),
    parameter int DIGITS      = REG_W / 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REGS*REG_W-1:0] regs_flat,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    auto_en,
    input  logic                    step,
    input  logic                    freeze,
    output logic [SEL_W-1:0]        cur_idx,
    output logic [7*DIGITS-1:0]     displ
);

    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [SEL_W-1:0]    idx_r, idx_s, idx_inc_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic                auto_q_r, auto_q_s;
    logic [7*DIGITS-1:0] displ_r, displ_s;
    logic [REG_W-1:0]    val_s;
    logic                blank_s;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Walk digits from the top so a run of leading zeros can be tracked
    function automatic logic [7*DIGITS-1:0] seg_word(input logic [REG_W-1:0] v, input logic blank);
        logic [7*DIGITS-1:0] w;
        logic [3:0]          nib;
        logic                lead;
        w    = '0;
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            nib = v[4*k +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            lead = lead && (nib == 4'h0) && (k != 0);
`else
            lead = 1'b0;
`endif
            w[7*k +: 7] = (blank || lead) ? 7'h7F : seg7(nib);
        end
        return w;
    endfunction

    // Register select for the display value, blanking out-of-range indices
    always_comb begin
        val_s   = '0;
        blank_s = (int'(idx_r) >= N_REGS);
        for (int i = 0; i < N_REGS; i++) begin
            val_s = (idx_r == SEL_W'(i)) ? regs_flat[i*REG_W +: REG_W] : val_s;
        end
    end

    // Next index, dwell counter and edge detector; an auto_en rise seen while frozen stays pending
    always_comb begin
        idx_inc_s = (int'(idx_r) >= N_REGS - 1) ? '0 : idx_r + SEL_W'(1);
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        auto_q_s  = auto_q_r;
        displ_s   = displ_r;
        if (!freeze) begin
            auto_q_s = auto_en;
            displ_s  = seg_word(val_s, blank_s);
            if (!(auto_en && auto_q_r)) begin
                idx_s = sel;
                cnt_s = '0;
            end else if (step || (cnt_r == CNT_LAST)) begin
                idx_s = idx_inc_s;
                cnt_s = '0;
            end else begin
                cnt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            idx_s    = idx_r;
            cnt_s    = cnt_r;
            auto_q_s = auto_q_r;
            displ_s  = displ_r;
        end
    end

    // State registers; reset overrides freeze
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r    <= '0;
            cnt_r    <= '0;
            auto_q_r <= 1'b0;
            displ_r  <= seg_word('0, 1'b0);
        end else begin
            idx_r    <= idx_s;
            cnt_r    <= cnt_s;
            auto_q_r <= auto_q_s;
            displ_r  <= displ_s;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        cur_idx = idx_r;
        displ   = displ_r;
    end

endmodule

// File: doc/reg_display_scanner.md
REG_DISPLAY_SCANNER -- requirements
Module: reg_display_scanner

Interface
REQ-001 The block SHALL have parameter N_REGS, default 8, the number of selectable registers, legal range 2..16.
REQ-002 The block SHALL have parameter REG_W, default 16, the register width in bits, a multiple of 4 in the range 4..32; DIGITS = REG_W/4.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 50_000_000, the auto-mode dwell time per register in clocks, minimum 2.
REQ-004 The block SHALL use SEL_W = clog2(N_REGS) as the width of its select and index ports.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port regs_flat, input, N_REGS*REG_W bits: register i occupies bits [i*REG_W +: REG_W].
REQ-008 The block SHALL have port sel, input, SEL_W bits: register index used in manual mode.
REQ-009 The block SHALL have port auto_en, input, 1 bit: 1 selects auto-scan mode, 0 selects manual mode.
REQ-010 The block SHALL have port step, input, 1 bit: single-cycle pulse that advances the index in auto mode.
REQ-011 The block SHALL have port freeze, input, 1 bit: while 1, hold the displayed value and index.
REQ-012 The block SHALL have port cur_idx, output, SEL_W bits, registered: the index currently displayed.
REQ-013 The block SHALL have port displ, output, 7*DIGITS bits, registered: digit k occupies [7k +: 7] with digit 0 the least significant nibble, bit 0 = segment a, active-low.

Function
REQ-014 In manual mode, the index register SHALL load sel every cycle.
REQ-015 The value register SHALL capture regs_flat[idx*REG_W +: REG_W] every cycle, and displ SHALL be decoded from the value register: sel change to displ change = 2 cycles.
REQ-016 If the index is >= N_REGS, the value SHALL be blanked and every digit SHALL show 7'h7F (all segments off).
REQ-017 The decode SHALL be hex 0-F with standard active-low patterns, e.g. 0 = 7'h40, 8 = 7'h00, F = 7'h0E.
REQ-018 Auto mode SHALL have a dwell counter that runs from 0 to HOLD_CYCLES-1; on the terminal count the index SHALL increment and the counter SHALL clear.
REQ-019 In auto mode the index SHALL wrap from N_REGS-1 to 0.
REQ-020 On the cycle auto_en rises, the index SHALL load sel and the counter SHALL clear; auto-scan continues from there.
REQ-021 A step pulse in auto mode SHALL advance the index by 1 (with wrap) and clear the counter.
REQ-022 If step coincides with the terminal count, the index SHALL advance by exactly 1.
REQ-023 In manual mode, step SHALL be ignored and the counter SHALL be held at 0.
REQ-024 While freeze = 1, the index, counter and value registers SHALL all hold, and sel, step and dwell expiry SHALL be ignored.
REQ-025 When freeze falls, operation SHALL resume from the held state, and the counter SHALL not be reset.
REQ-026 If freeze and a rising auto_en occur in the same cycle, freeze SHALL win and the rising edge SHALL be acted on at the first unfrozen cycle while auto_en is still 1.
REQ-027 cur_idx SHALL equal the index register.

Reset
REQ-028 When rst_n = 0 at a clock edge, the index, counter and value registers SHALL clear to 0 and the auto_en edge detector SHALL clear, overriding freeze.
REQ-029 After reset, displ SHALL show 0 on every digit (7'h40 each) and cur_idx SHALL be 0.
REQ-030 Reset asserted mid-dwell SHALL restart the dwell count from 0.

Configuration
REQ-031 When macro SEG_LEADING_ZERO_BLANK_EN is defined, zero digits above the most significant non-zero digit SHALL be blanked (7'h7F).
REQ-032 With SEG_LEADING_ZERO_BLANK_EN defined, digit 0 SHALL always be displayed, so value 0 shows a single "0"; the reset displ SHALL be 7'h40 on digit 0 and 7'h7F on the others.
REQ-033 When SEG_LEADING_ZERO_BLANK_EN is undefined, all digits SHALL always be displayed; latency is 2 cycles in both builds.

Verification
REQ-034 Manual, defaults: reg3 = 16'hBEEF, sel = 3 -> displ digits F,E,E,B and cur_idx = 3 two cycles later.
REQ-035 Auto with HOLD_CYCLES = 4, sel = 6, auto_en rises -> cur_idx 6,7,0,1, changing every 4 cycles.
REQ-036 Auto with step on the terminal-count cycle -> index advances by exactly 1 and the next dwell lasts a full 4 cycles.
REQ-037 freeze held for 10 cycles in auto mode while regs_flat changes -> displ and cur_idx unchanged; scan resumes with the remaining dwell.
REQ-038 N_REGS = 5, sel = 7 -> all digits 7'h7F.
REQ-039 SEG_LEADING_ZERO_BLANK_EN defined, value 16'h0030 -> digits 3 and 2 are 7'h7F, digits 1 and 0 show 3 and 0.
REQ-040 rst_n low mid-dwell with freeze = 1 -> cur_idx = 0 and displ = reset pattern on the following cycle.
